// File: rtl/rtc_apb_pkg.sv
// ============================================================================
// rtc_apb_pkg : shared types and RTC register map for the APB requester.
// Rev 1.0
// ============================================================================
`default_nettype none

package rtc_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } apb_rsp_t;

  // RTC register word indices; byte address = index * REGS_OFFSET
  localparam int REG_DATE        = 0;
  localparam int REG_CLOCK       = 1;
  localparam int REG_ALARM_DATE  = 2;
  localparam int REG_ALARM_CLOCK = 3;
  localparam int REG_CTRL        = 4;
  localparam int REG_EVENT_EN    = 5;
  localparam int REG_EVENT_FLAG  = 6;
  localparam int REG_PRESCALE    = 7;
  localparam int REG_UPDATE      = 8;
  localparam int REGS_OFFSET     = 4;

  localparam int EVT_ALARM_BIT = 0;
  localparam int EVT_TICK_BIT  = 1;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_apb_timeout_cnt.sv
// ============================================================================
// rtc_apb_timeout_cnt : saturating ACCESS-phase wait counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module rtc_apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr, en};
      assign expired       = 1'b0;
    end else begin : g_enabled
      localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
          cnt <= cnt + 1'b1;
        end
      end

      // High in the waiting cycle whose increment reaches the limit
      assign expired = en && (cnt == LIMIT - 1'b1);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rtc_apb_master.sv
// ============================================================================
// rtc_apb_master : valid/ready command port to APB3/4 requester with timeout.
// Rev 1.0
// ============================================================================
`default_nettype none

module rtc_apb_master
  import rtc_apb_pkg::*;
#(
  parameter int         APB_ADDR_W     = 32,
  parameter int         APB_DATA_W     = 32,
  parameter int         TIMEOUT_CYCLES = 256,
  parameter logic [2:0] PPROT_VAL      = 3'b000
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [APB_ADDR_W-1:0]   req_addr,
  input  logic [APB_DATA_W-1:0]   req_wdata,
  input  logic [APB_DATA_W/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [APB_DATA_W-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    m_psel,
  output logic                    m_penable,
  output logic                    m_pwrite,
  output logic [APB_ADDR_W-1:0]   m_paddr,
  output logic [APB_DATA_W-1:0]   m_pwdata,
  output logic [APB_DATA_W/8-1:0] m_pstrb,
  output logic [2:0]              m_pprot,
  input  logic [APB_DATA_W-1:0]   m_prdata,
  input  logic                    m_pready,
  input  logic                    m_pslverr
);

  apb_state_e state;
  logic       tmo_clr;
  logic       tmo_en;
  logic       tmo_expired;

  assign tmo_clr = (state == ST_SETUP);
  assign tmo_en  = (state == ST_ACCESS) && !m_pready;
  assign m_pprot = PPROT_VAL;

  rtc_apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (pclk),
    .rst    (prst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge pclk) begin
    if (prst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      m_psel      <= 1'b0;
      m_penable   <= 1'b0;
      m_pwrite    <= 1'b0;
      m_paddr     <= '0;
      m_pwdata    <= '0;
      m_pstrb     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            m_pwrite  <= req_write;
            m_paddr   <= req_addr;
            m_pwdata  <= req_wdata;
            m_pstrb   <= req_write ? req_strb : '0;
            // Misaligned commands never reach the bus
            if (is_misaligned(req_addr[1:0])) begin
              state       <= ST_RESP;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              state  <= ST_SETUP;
              m_psel <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          m_penable <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (m_pready) begin
            m_psel      <= 1'b0;
            m_penable   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= m_pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!m_pwrite && !m_pslverr) ? m_prdata : '0;
            state       <= ST_RESP;
          end else if (tmo_expired) begin
            m_psel      <= 1'b0;
            m_penable   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            req_ready   <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rtc_apb_master.sv
// ============================================================================
// tb_rtc_apb_master : directed bench with per-cycle schedule model and APB slave.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rtc_apb_master;
  import rtc_apb_pkg::*;

  localparam int         TMO   = 8;
  localparam logic [2:0] PPROT = 3'b010;
  localparam int         NCYC  = 1024;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic [3:0]  m_pstrb;
  logic [2:0]  m_pprot;

  always #5 pclk = ~pclk;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  rtc_apb_master #(
    .APB_ADDR_W(32), .APB_DATA_W(32), .TIMEOUT_CYCLES(TMO), .PPROT_VAL(PPROT)
  ) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  // ---------------- APB slave: configurable wait states / error / stuck
  int          cfg_waits = 0;
  logic        cfg_err = 1'b0, cfg_stuck = 1'b0, cfg_ovr_en = 1'b0;
  logic [31:0] cfg_ovr = '0;
  logic [31:0] slv_regs [0:15] = '{default: '0};
  int          slv_acc = 0;

  assign m_pready  = m_psel && m_penable && !cfg_stuck && (slv_acc == cfg_waits);
  assign m_pslverr = m_pready && cfg_err;
  assign m_prdata  = cfg_ovr_en ? cfg_ovr : slv_regs[m_paddr[5:2]];

  always @(posedge pclk) begin
    if (m_psel && m_penable && !m_pready) slv_acc <= slv_acc + 1;
    else                                  slv_acc <= 0;
    if (m_pready && m_pwrite && !cfg_err)
      for (int b = 0; b < 4; b++)
        if (m_pstrb[b]) slv_regs[m_paddr[5:2]][8*b +: 8] <= m_pwdata[8*b +: 8];
  end

  // ---------------- model: expected outputs per cycle
  typedef struct {
    logic        psel, pen, rv, rr, pwrite, err, to;
    logic [31:0] paddr, pwdata, rdata;
    logic [3:0]  pstrb;
  } exp_t;

  exp_t        exp_c [0:NCYC-1];
  logic [31:0] mdl_regs [0:15];

  function automatic exp_t mk(input logic psel, pen, rv, wr, input logic [31:0] a, d,
                              input logic [3:0] s, input logic [31:0] rd, input logic er, tm);
    exp_t e;
    e.psel = psel; e.pen = pen; e.rv = rv; e.rr = 1'b0; e.pwrite = wr;
    e.paddr = a; e.pwdata = d; e.pstrb = s; e.rdata = rd; e.err = er; e.to = tm;
    return e;
  endfunction

  task automatic set_idle(input int c);
    exp_c[c] = mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    exp_c[c].rr = 1'b1;
  endtask

  // Transfer accepted in cycle n; returns first response cycle r
  task automatic model_txn(input logic wr, input logic [31:0] a, d, input logic [3:0] s,
                           input int waits, input logic slverr, stuck, ovr_en,
                           input logic [31:0] ovr, input int n, hold, output int r);
    logic mis, tmo, err;
    logic [31:0] rd;
    logic [3:0]  ps;
    int k;
    mis = (a[1:0] != 2'b00);
    ps  = wr ? s : 4'b0;
    tmo = 1'b0;
    if (mis) begin
      err = 1'b1;
      r   = n + 1;
    end else begin
      if (stuck || (waits + 1 > TMO)) begin k = TMO; tmo = 1'b1; end
      else k = waits + 1;
      err = tmo || slverr;
      exp_c[n+1] = mk(1'b1, 1'b0, 1'b0, wr, a, d, ps, '0, 1'b0, 1'b0);
      for (int i = 0; i < k; i++)
        exp_c[n+2+i] = mk(1'b1, 1'b1, 1'b0, wr, a, d, ps, '0, 1'b0, 1'b0);
      r = n + 2 + k;
    end
    rd = (!wr && !err) ? (ovr_en ? ovr : mdl_regs[a[5:2]]) : 32'h0;
    if (!mis && wr && !err)
      for (int b = 0; b < 4; b++) if (s[b]) mdl_regs[a[5:2]][8*b +: 8] = d[8*b +: 8];
    for (int c = r; c <= r + hold; c++)
      exp_c[c] = mk(1'b0, 1'b0, 1'b1, wr, a, d, ps, rd, err, tmo);
  endtask

  task automatic model_reset(input int c);
    for (int i = c + 1; i < c + 41; i++) set_idle(i);
  endtask

  // ---------------- compare + monitor (single process owns the counters)
  int          n_cmp = 0, n_err = 0;
  int          mon_acc = 0, mon_psel = 0, mon_rsp_cyc = 0;
  apb_rsp_t    mon_rsp;
  logic        prev_rv = 1'b0;
  logic        lit_req = 1'b0;
  string       lit_name = "";
  logic [31:0] lit_act = '0, lit_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      exp_t e;
      e = exp_c[cyc];
      chk("req_ready", 32'(req_ready), 32'(e.rr));
      chk("m_psel",    32'(m_psel),    32'(e.psel));
      chk("m_penable", 32'(m_penable), 32'(e.pen));
      chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
      chk("m_pprot",   32'(m_pprot),   32'(PPROT));
      if (e.psel) begin
        chk("m_paddr",  m_paddr,           e.paddr);
        chk("m_pwrite", 32'(m_pwrite),     32'(e.pwrite));
        chk("m_pstrb",  32'(m_pstrb),      32'(e.pstrb));
        if (e.pwrite) chk("m_pwdata", m_pwdata, e.pwdata);
      end
      if (e.rv) begin
        chk("rsp_rdata",   rsp_rdata,          e.rdata);
        chk("rsp_err",     32'(rsp_err),       32'(e.err));
        chk("rsp_timeout", 32'(rsp_timeout),   32'(e.to));
      end
    end
    if (lit_req) chk(lit_name, lit_act, lit_exp);
    if (m_psel && m_penable) mon_acc++;
    if (m_psel) mon_psel++;
    if (rsp_valid && !prev_rv) begin
      mon_rsp_cyc = cyc;
      mon_rsp     = '{rdata: rsp_rdata, err: rsp_err, timeout: rsp_timeout};
    end
    prev_rv = rsp_valid;
  end

  // ---------------- driver
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_name = name; lit_act = act; lit_exp = exp; lit_req = 1'b1;
    @(negedge pclk); #1;
    lit_req = 1'b0;
    @(posedge pclk); #1;
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the posedge
  // following the response handshake (or the reset pulse).
  task automatic do_txn(input logic wr, input logic [31:0] a, d, input logic [3:0] s,
                        input int waits, input logic slverr, stuck, ovr_en,
                        input logic [31:0] ovr, input int hold, rst_at, output int n);
    int r, last;
    n = cyc;
    cfg_waits = waits; cfg_err = slverr; cfg_stuck = stuck; cfg_ovr_en = ovr_en; cfg_ovr = ovr;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
    model_txn(wr, a, d, s, waits, slverr, stuck, ovr_en, ovr, n, hold, r);
    last = r + hold;
    @(posedge pclk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    while (cyc <= last) begin
      if (rst_at != 0 && cyc == n + rst_at) begin
        prst = 1'b1;
        model_reset(cyc);
        @(posedge pclk); #1;
        prst = 1'b0;
        rsp_ready = 1'b0;
        return;
      end
      rsp_ready = (cyc == last);
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, a0, p0;
    for (int i = 0; i < NCYC; i++) set_idle(i);
    for (int i = 0; i < 16; i++) mdl_regs[i] = '0;

    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;
    lit("rst_req_ready", 32'(req_ready), 32'h1);
    lit("rst_rsp_rdata", rsp_rdata, 32'h0);
    lit("rst_m_pprot", 32'(m_pprot), 32'h2);

    // Zero-wait write to CLOCK
    a0 = mon_acc;
    do_txn(1'b1, 32'h4, 32'h0000_1234, 4'hF, 0, 1'b0, 1'b0, 1'b0, '0, 0, 0, n);
    lit("wr_latency", 32'(mon_rsp_cyc - n), 32'd3);
    lit("wr_access_cycles", 32'(mon_acc - a0), 32'd1);
    lit("wr_err", 32'(mon_rsp.err), 32'h0);

    // CLOCK readback, then back-to-back read with 3 wait states
    do_txn(1'b0, 32'h4, '0, 4'hF, 0, 1'b0, 1'b0, 1'b0, '0, 0, 0, n);
    a0 = mon_acc;
    do_txn(1'b0, 32'h0, '0, 4'h0, 3, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 0, 0, n);
    lit("ws3_access_cycles", 32'(mon_acc - a0), 32'd4);
    lit("ws3_rdata", mon_rsp.rdata, 32'hCAFE_0001);
    do_txn(1'b0, 32'h4, '0, 4'hF, 0, 1'b0, 1'b0, 1'b0, '0, 0, 0, n);
    lit("clock_readback", mon_rsp.rdata, 32'h0000_1234);

    // Slave error on EVENT_FLAG write
    do_txn(1'b1, 32'(REG_EVENT_FLAG * REGS_OFFSET), 32'h3, 4'hF, 0, 1'b1, 1'b0, 1'b0, '0, 1, 0, n);
    lit("slverr_err", 32'(mon_rsp.err), 32'h1);
    lit("slverr_timeout", 32'(mon_rsp.timeout), 32'h0);

    // Hung slave -> timeout after TMO access cycles
    a0 = mon_acc;
    do_txn(1'b0, 32'h8, '0, 4'h0, 0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 2, 0, n);
    lit("tmo_access_cycles", 32'(mon_acc - a0), 32'd8);
    lit("tmo_flags", {30'b0, mon_rsp.err, mon_rsp.timeout}, 32'h3);
    lit("tmo_rdata", mon_rsp.rdata, 32'h0);

    // pready on the last allowed cycle beats the timeout
    a0 = mon_acc;
    do_txn(1'b0, 32'h8, '0, 4'h0, 7, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA, 0, 0, n);
    lit("edge_access_cycles", 32'(mon_acc - a0), 32'd8);
    lit("edge_rdata", mon_rsp.rdata, 32'h5555_AAAA);
    lit("edge_flags", {30'b0, mon_rsp.err, mon_rsp.timeout}, 32'h0);

    // Misaligned write, response held for 5 cycles
    p0 = mon_psel;
    do_txn(1'b1, 32'h6, 32'h1111_2222, 4'hF, 0, 1'b0, 1'b0, 1'b0, '0, 5, 0, n);
    lit("misalign_psel_cycles", 32'(mon_psel - p0), 32'd0);
    lit("misalign_latency", 32'(mon_rsp_cyc - n), 32'd1);

    // Partial-strobe write then readback
    do_txn(1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, 1, 1'b0, 1'b0, 1'b0, '0, 0, 0, n);
    do_txn(1'b0, 32'h8, '0, 4'hF, 0, 1'b0, 1'b0, 1'b0, '0, 0, 0, n);
    lit("strobe_readback", mon_rsp.rdata, 32'h00BB_00DD);

    // Reset during ACCESS, then a normal transfer
    do_txn(1'b0, 32'hC, '0, 4'h0, 0, 1'b0, 1'b1, 1'b0, '0, 0, 3, n);
    do_txn(1'b0, 32'h4, '0, 4'hF, 2, 1'b0, 1'b0, 1'b0, '0, 0, 0, n);
    lit("post_reset_rdata", mon_rsp.rdata, 32'h0000_1234);

    repeat (3) @(posedge pclk);
    @(negedge pclk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
